// File: rtl/idlegen_pkg.sv
// Shared constants and types for the DisplayPort idle-pattern source (idlegen).
package idlegen_pkg;

  localparam logic [7:0] symBS    = 8'hBC;
  // VB-ID with NoVideoStream=1 and VerticalBlanking=1
  localparam logic [7:0] vbidIDLE = 8'h09;

  typedef enum logic {
    IGIDLE  = 1'b0,
    IGVIDEO = 1'b1
  } ig_state_t;

  typedef struct packed {
    ig_state_t state;
    logic      exit_wait;
    logic      lane0_bs;
  } idlegen_dbg_t;

endpackage

// File: rtl/idlegen.sv
// Idle-pattern / framer link symbol source, two symbols per clock, upstream of the scrambler.
// Build option IDLEGEN_MAUD_EN: carry the maud port as the Maud byte (else Maud is 0x00).
module idlegen
  import idlegen_pkg::*;
#(
  parameter int PERIOD = 8192
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        video_en,
  input  logic [15:0] indata,
  input  logic [1:0]  inisk,
  input  logic [7:0]  mvid,
  input  logic [7:0]  maud,
  output logic [15:0] outdata,
  output logic [1:0]  outisk,
  output logic        invideo
);

  localparam int CTR_W = $clog2(PERIOD / 2);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(PERIOD / 2 - 1);

  // Handshake: none. video_en is a level request sampled every clock; the
  // framer stream has no valid/ready and is consumed every cycle in VIDEO.

  ig_state_t        state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [15:0]      data_d;
  logic [1:0]       isk_d;
  logic             invideo_d;
  logic [7:0]       maud_b;
  logic             lane0_bs;
  idlegen_dbg_t     dbg;

`ifdef IDLEGEN_MAUD_EN
  assign maud_b = maud;
`else
  logic [7:0] maud_unused;
  assign maud_unused = maud;
  assign maud_b      = 8'h00;
`endif

  // Only a lane-0 BS is a legal switch point; a lane-1 BS would split the cadence.
  assign lane0_bs = inisk[0] && (indata[7:0] == symBS);

  assign dbg.state     = state_q;
  assign dbg.exit_wait = (state_q == IGVIDEO) && !video_en;
  assign dbg.lane0_bs  = lane0_bs;

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    invideo_d = 1'b0;
    data_d    = 16'h0000;
    isk_d     = 2'b00;

    if (ctr_q == '0) begin
      data_d = {vbidIDLE, symBS};
      isk_d  = 2'b01;
    end else if (ctr_q == CTR_W'(1)) begin
      data_d = {maud_b, mvid};
      isk_d  = 2'b00;
    end

    case (state_q)
      IGIDLE: begin
        if ((ctr_q == '0) && video_en) begin
          state_d   = IGVIDEO;
          data_d    = indata;
          isk_d     = inisk;
          invideo_d = 1'b1;
          ctr_d     = '0;
        end else if (ctr_q == CTR_LAST) begin
          ctr_d = '0;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      IGVIDEO: begin
        // ctr is held at 0 here, so the idle defaults above are already cycle 0.
        if (!video_en && lane0_bs) begin
          state_d = IGIDLE;
          ctr_d   = CTR_W'(1);
        end else begin
          data_d    = indata;
          isk_d     = inisk;
          invideo_d = 1'b1;
          ctr_d     = '0;
        end
      end
      default: begin
        state_d = IGIDLE;
        ctr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IGIDLE;
      ctr_q   <= '0;
      outdata <= 16'h0000;
      outisk  <= 2'b00;
      invideo <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      outdata <= data_d;
      outisk  <= isk_d;
      invideo <= invideo_d;
    end
  end

endmodule
